// File: rtl/skid_fifo_break_r.sv
// -----------------------------------------------------------------------------
// skid_fifo_break_r
//
// Purpose:
//   A transparent FIFO with NUM_SLOTS entries that cuts the ready path.
//   ins_ready comes straight from a flop, so there is no combinational path
//   from outs_ready back to ins_ready.
//   When the FIFO is empty, the upstream token is presented downstream in the
//   same cycle (0-cycle bypass). That token is stored only if downstream does
//   not take it.
//
// Parameters:
//   NUM_SLOTS  storage depth, 1..64 (non power-of-two values are allowed)
//   DATA_TYPE  data width in bits, 1..1024
//
// Ports:
//   clk         clock; all state updates on its rising edge
//   rst         synchronous, active-high reset
//   ins         upstream data
//   ins_valid   upstream valid
//   ins_ready   upstream ready (registered)
//   outs        downstream data
//   outs_valid  downstream valid
//   outs_ready  downstream ready
//   occupancy   stored-token count. This port exists only when the macro
//               SKID_FIFO_OCCUPANCY_EN is defined.
//
// Handshake:
//   A transfer happens on a side when valid and ready are both high at a
//   rising clk edge. The producer holds data stable while it waits for ready.
//   Here, outs stays stable while outs_valid=1 and outs_ready=0 with tokens
//   stored.
// -----------------------------------------------------------------------------
module skid_fifo_break_r #(
   parameter int NUM_SLOTS = 4,
   parameter int DATA_TYPE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_TYPE-1:0] ins,
   input  logic                 ins_valid,
   output logic                 ins_ready,
   output logic [DATA_TYPE-1:0] outs,
   output logic                 outs_valid,
   input  logic                 outs_ready
`ifdef SKID_FIFO_OCCUPANCY_EN
   ,
   output logic [$clog2(NUM_SLOTS+1)-1:0] occupancy
`endif
);

   localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int CW = $clog2(NUM_SLOTS + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(NUM_SLOTS - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(NUM_SLOTS);

   logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];
   logic [PW-1:0]        head_q, head_d;
   logic [PW-1:0]        tail_q, tail_d;
   logic [CW-1:0]        count_q, count_d;
   // ready_q is the inverse of "full". Holding it in this polarity lets
   // ins_ready be a bare flop output.
   logic                 ready_q;

   logic empty;
   logic in_xfer;
   logic out_xfer;
   logic wr_en;
   logic rd_en;

   always_comb begin
      empty      = (count_q == '0);
      outs       = empty ? ins : mem_q[head_q];
      outs_valid = empty ? ins_valid : 1'b1;
      in_xfer    = ins_valid & ready_q;
      out_xfer   = outs_valid & outs_ready;
      // When empty and downstream is ready, the token goes straight through
      // and is never written into storage.
      wr_en      = in_xfer & ~(empty & outs_ready);
      rd_en      = out_xfer & ~empty;
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (rd_en) head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
      if (wr_en) tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ready_q <= 1'b1;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ready_q <= (count_d != FULL_CNT);
      end
   end

   // Storage has no reset. A write during reset is suppressed so that the
   // reset cycle leaves no trace.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem_q[tail_q] <= ins;
   end

   assign ins_ready = ready_q;

`ifdef SKID_FIFO_OCCUPANCY_EN
   assign occupancy = count_q;
`endif

endmodule

// File: tb/tb_skid_fifo_break_r.sv
// -----------------------------------------------------------------------------
// tb_skid_fifo_break_r
//
// Drives two instances of skid_fifo_break_r:
//   u_dut4  NUM_SLOTS=4, used for bypass, fill, drain, full read/write and
//           mid-operation reset.
//   u_dut3  NUM_SLOTS=3, used for the wrap-around ordering run.
// Inputs change 1 time unit after the rising edge. Outputs are sampled
// 1 time unit after that, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_skid_fifo_break_r;

   localparam int W = 8;

   logic clk;
   logic rst;

   logic [W-1:0] ins4, outs4;
   logic         v4, rdy4, ov4, ordy4;
   logic [W-1:0] ins3, outs3;
   logic         v3, rdy3, ov3, ordy3;
`ifdef SKID_FIFO_OCCUPANCY_EN
   logic [2:0] occ4;
   logic [1:0] occ3;
`endif

   int total;
   int bad;
   logic [W-1:0] exp_q[$];

   skid_fifo_break_r #(.NUM_SLOTS(4), .DATA_TYPE(W)) u_dut4 (
      .clk(clk), .rst(rst),
      .ins(ins4), .ins_valid(v4), .ins_ready(rdy4),
      .outs(outs4), .outs_valid(ov4), .outs_ready(ordy4)
`ifdef SKID_FIFO_OCCUPANCY_EN
      , .occupancy(occ4)
`endif
   );

   skid_fifo_break_r #(.NUM_SLOTS(3), .DATA_TYPE(W)) u_dut3 (
      .clk(clk), .rst(rst),
      .ins(ins3), .ins_valid(v3), .ins_ready(rdy3),
      .outs(outs3), .outs_valid(ov3), .outs_ready(ordy3)
`ifdef SKID_FIFO_OCCUPANCY_EN
      , .occupancy(occ3)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      int sent, got, cyc, hw, tw;
      logic [1:0] ph, pt;
      total = 0;
      bad   = 0;
      rst = 1'b1;
      ins4 = '0; v4 = 1'b0; ordy4 = 1'b0;
      ins3 = '0; v3 = 1'b0; ordy3 = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // reset state, empty bypass
      settle();
      check_eq("rst_ready", rdy4, 1);
      check_eq("rst_count", u_dut4.count_q, 0);
      check_eq("rst_ovalid_idle", ov4, 0);
`ifdef SKID_FIFO_OCCUPANCY_EN
      check_eq("rst_occ", occ4, 0);
`endif
      ins4 = 8'hA5; v4 = 1'b1; ordy4 = 1'b1;
      settle();
      check_eq("bypass_data", outs4, 8'hA5);
      check_eq("bypass_valid", ov4, 1);
      tick();
      v4 = 1'b0;
      check_eq("bypass_count", u_dut4.count_q, 0);

      // fill: outs must hold the first token throughout
      ordy4 = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         ins4 = 8'(i); v4 = 1'b1;
         settle();
         check_eq("fill_ready", rdy4, 1);
         check_eq("fill_head", outs4, 8'h01);
         tick();
      end
      check_eq("full_count", u_dut4.count_q, 4);
      check_eq("full_ready", rdy4, 0);
`ifdef SKID_FIFO_OCCUPANCY_EN
      check_eq("full_occ", occ4, 4);
`endif
      ins4 = 8'h05; v4 = 1'b1;
      settle();
      check_eq("full_ovalid", ov4, 1);
      check_eq("full_outs", outs4, 8'h01);
      tick();
      check_eq("reject_count", u_dut4.count_q, 4);

      // drain
      v4 = 1'b0; ordy4 = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         settle();
         check_eq("drain_data", outs4, 8'(k));
         check_eq("drain_valid", ov4, 1);
         tick();
         check_eq("drain_ready", rdy4, 1);
         check_eq("drain_count", u_dut4.count_q, 4 - k);
      end

      // refill, then read and offered write together while full
      ordy4 = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         ins4 = 8'(i); v4 = 1'b1;
         tick();
      end
      ins4 = 8'h05; v4 = 1'b1; ordy4 = 1'b1;
      settle();
      check_eq("fullrw_ready", rdy4, 0);
      check_eq("fullrw_outs", outs4, 8'h01);
      tick();
      check_eq("fullrw_count", u_dut4.count_q, 3);
      check_eq("fullrw_ready_back", rdy4, 1);
      v4 = 1'b0;
      settle();
      check_eq("fullrw_next", outs4, 8'h02);
      tick();
      check_eq("pre_rst_count", u_dut4.count_q, 2);
      settle();
      check_eq("pre_rst_outs", outs4, 8'h03);

      // mid-operation reset with both sides active in the reset cycle
      rst = 1'b1; ins4 = 8'h66; v4 = 1'b1; ordy4 = 1'b1;
      tick();
      rst = 1'b0; v4 = 1'b0; ordy4 = 1'b0;
      settle();
      check_eq("midrst_count", u_dut4.count_q, 0);
      check_eq("midrst_ready", rdy4, 1);
      check_eq("midrst_ovalid", ov4, 0);
`ifdef SKID_FIFO_OCCUPANCY_EN
      check_eq("midrst_occ", occ4, 0);
`endif
      ins4 = 8'h77; v4 = 1'b1;
      settle();
      check_eq("midrst_bypass_v", ov4, 1);
      check_eq("midrst_bypass_d", outs4, 8'h77);
      tick();
      v4 = 1'b0;

      // wrap: 3 slots, tokens 0..9, random valid/ready
      sent = 0; got = 0; cyc = 0; hw = 0; tw = 0;
      while (got < 10 && cyc < 400) begin
         ins3 = 8'(sent);
         v3 = (sent < 10) && ($urandom_range(0, 1) == 1);
         // ready only while tokens are stored, so every token goes through storage
         ordy3 = (exp_q.size() != 0) && ($urandom_range(0, 2) != 0);
         settle();
         if (v3 && rdy3) begin
            exp_q.push_back(8'(sent));
            sent++;
         end
         if (ov3 && ordy3) begin
            check_eq("wrap_data", outs3, exp_q.pop_front());
            got++;
         end
         ph = u_dut3.head_q;
         pt = u_dut3.tail_q;
         tick();
         if (ph == 2'd2 && u_dut3.head_q == 2'd0) hw++;
         if (pt == 2'd2 && u_dut3.tail_q == 2'd0) tw++;
         cyc++;
      end
      v3 = 1'b0; ordy3 = 1'b0;
      check_eq("wrap_received", got, 10);
      check_eq("wrap_leftover", exp_q.size(), 0);
      check_eq("wrap_head_twice", hw >= 2, 1);
      check_eq("wrap_tail_twice", tw >= 2, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/skid_fifo_break_r.md
SKID_FIFO_BREAK_R -- requirements
Module: skid_fifo_break_r

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of storage slots; legal range 1..64; values that are not a power of two are legal.
REQ-002 SHALL have parameter DATA_TYPE, default 32, data width in bits; legal range 1..1024.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ins, input, DATA_TYPE, upstream data.
REQ-006 SHALL have port ins_valid, input, 1, upstream valid.
REQ-007 SHALL have port ins_ready, output, 1, upstream ready; driven directly by a flop.
REQ-008 SHALL have port outs, output, DATA_TYPE, downstream data.
REQ-009 SHALL have port outs_valid, output, 1, downstream valid.
REQ-010 SHALL have port outs_ready, input, 1, downstream ready.
REQ-011 SHALL have port occupancy, output, clog2(NUM_SLOTS+1), stored-token count; present only per REQ-030.

Function
REQ-012 SHALL implement a transparent FIFO of NUM_SLOTS entries that breaks the ready path: no combinational path from outs_ready to ins_ready.
REQ-013 SHALL keep state: storage array, head pointer, tail pointer, count (0..NUM_SLOTS), full_reg.
REQ-014 SHALL drive ins_ready = ~full_reg, where full_reg is registered as (next count == NUM_SLOTS).
REQ-015 SHALL, when count==0, drive outs=ins and outs_valid=ins_valid combinationally (0-cycle bypass).
REQ-016 SHALL, when count>0, drive outs=storage[head] and outs_valid=1.
REQ-017 SHALL treat the input transfer as ins_valid & ins_ready, and the output transfer as outs_valid & outs_ready.
REQ-018 SHALL write ins into storage[tail] on input transfer, except when count==0 and outs_ready=1 (bypass consumed; no write).
REQ-019 SHALL advance head on output transfer only when count>0.
REQ-020 SHALL wrap head and tail from NUM_SLOTS-1 to 0.
REQ-021 SHALL leave count unchanged on a simultaneous write and read, including at count==NUM_SLOTS-1 and while full_reg=0.
REQ-022 SHALL, when full (ins_ready=0), ignore ins_valid; a read in that cycle frees a slot and ins_ready returns to 1 the next cycle.
REQ-023 SHALL preserve strict FIFO order with no loss or duplication of tokens.
REQ-024 SHALL hold outs stable while outs_valid=1 and outs_ready=0 with count>0.
REQ-025 SHALL, with NUM_SLOTS=1, behave as a single-slot bypassable skid register.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set count=0, head=0, tail=0, full_reg=0 (ins_ready=1).
REQ-027 SHALL discard all stored tokens on reset mid-operation; input and output transfers in the reset cycle have no effect on state.
REQ-028 SHALL NOT require reset of storage contents.
REQ-029 SHALL drive outs_valid=ins_valid in the first cycle after reset (empty bypass).

Configuration
REQ-030 SHALL compile in the occupancy output and its logic only when macro SKID_FIFO_OCCUPANCY_EN is defined; occupancy equals registered count, 0 after reset.
REQ-031 SHALL, without SKID_FIFO_OCCUPANCY_EN, omit the occupancy port and remain otherwise cycle-identical.

Verification
REQ-032 SHALL verify bypass: NUM_SLOTS=4, empty, ins=0xA5, ins_valid=1, outs_ready=1 -> same cycle outs=0xA5, outs_valid=1; count stays 0.
REQ-033 SHALL verify fill: outs_ready=0, push 0x01..0x04 -> ins_ready=0 in the cycle after the 4th transfer; the 5th token 0x05 is not accepted; outs=0x01.
REQ-034 SHALL verify drain: from full, outs_ready=1, ins_valid=0 -> outs 0x01,0x02,0x03,0x04 on consecutive cycles; ins_ready=1 from the cycle after the first read.
REQ-035 SHALL verify wrap: NUM_SLOTS=3, 10 tokens 0..9 with random valid/ready -> output sequence 0..9 exactly; head and tail each wrap at least twice.
REQ-036 SHALL verify full with simultaneous read and write: at count=4, outs_ready=1, ins_valid=1 -> input not accepted; next cycle count=3, ins_ready=1.
REQ-037 SHALL verify mid-operation reset: rst=1 at count=2 -> next cycle count=0, ins_ready=1, outs_valid=ins_valid; with SKID_FIFO_OCCUPANCY_EN defined, occupancy=0.
